// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants, controller state encoding and latency selection.
// Used by the ALU, the control unit and the issue controller.
package alu_pkg;

    localparam logic [4:0] OP_NOP     = 5'd0;
    localparam logic [4:0] OP_ADD     = 5'd1;
    localparam logic [4:0] OP_SUB     = 5'd2;
    localparam logic [4:0] OP_MUL     = 5'd3;
    localparam logic [4:0] OP_DIV     = 5'd4;
    localparam logic [4:0] OP_AND     = 5'd5;
    localparam logic [4:0] OP_OR      = 5'd6;
    localparam logic [4:0] OP_XOR     = 5'd7;
    localparam logic [4:0] OP_SHL     = 5'd8;
    localparam logic [4:0] OP_SHR     = 5'd9;
    localparam logic [4:0] OP_SRA     = 5'd10;
    localparam logic [4:0] OP_ROL     = 5'd11;
    localparam logic [4:0] OP_ROR     = 5'd12;
    localparam logic [4:0] OP_LOG_AND = 5'd13;
    localparam logic [4:0] OP_LOG_OR  = 5'd14;
    localparam logic [4:0] OP_LOG_NOT = 5'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } issue_state_t;

    // Only mul and div are multi-cycle; everything else, including illegal codes, takes one cycle.
    function automatic logic [3:0] lat_sel(
        input logic [4:0] op,
        input logic [3:0] mul_lat,
        input logic [3:0] div_lat
    );
        logic [3:0] lat;
        case (op)
            OP_MUL:  lat = mul_lat;
            OP_DIV:  lat = div_lat;
            default: lat = 4'd1;
        endcase
        return lat;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational request decode: operation latency, divide-by-zero and illegal-opcode detection.
module alu_op_decode
    import alu_pkg::*;
#(
    parameter int WORD = 32
)
(
    input  logic [4:0]      opcode,
    input  logic [WORD-1:0] b,
    input  logic [3:0]      mul_lat,
    input  logic [3:0]      div_lat,
    output logic [3:0]      latency,
    output logic            is_div_zero,
    output logic            is_illegal
);

    // Opcodes 16..31 have no ALU meaning.
    always_comb begin
        is_illegal  = opcode[4];
        is_div_zero = (opcode == OP_DIV) && (b == {WORD{1'b0}});
        latency     = lat_sel(opcode, mul_lat, div_lat);
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one operation at a time to the ALU, waits out its latency and holds the
// captured 64-bit result with status flags until the consumer takes it.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int WORD    = 32,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 8
)
(
    input  logic              clk,
    input  logic              clr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [4:0]        req_opcode,
    input  logic [WORD-1:0]   req_a,
    input  logic [WORD-1:0]   req_b,
    output logic [WORD-1:0]   alu_a,
    output logic [WORD-1:0]   alu_b,
    output logic [4:0]        alu_opcode,
    output logic              alu_inc_pc,
    output logic              alu_conn_out,
    input  logic [2*WORD-1:0] alu_c,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [WORD-1:0]   res_hi,
    output logic [WORD-1:0]   res_lo,
    output logic              res_zero,
    output logic              res_neg,
    output logic              res_dz,
    output logic              res_illegal,
    output logic              busy
);

    localparam int CW = 2 * WORD;

    issue_state_t    state_r;
    logic [3:0]      cnt_r;
    logic            req_ready_r;
    logic            res_valid_r;
    logic            busy_r;
    logic [WORD-1:0] alu_a_r;
    logic [WORD-1:0] alu_b_r;
    logic [4:0]      alu_opcode_r;
    logic [WORD-1:0] res_hi_r;
    logic [WORD-1:0] res_lo_r;
    logic            res_zero_r;
    logic            res_neg_r;
    logic            dz_r;
    logic            ill_r;

    logic [3:0]      lat_s;
    logic            dz_s;
    logic            ill_s;
    logic [CW-1:0]   cap_s;
    logic            zero_s;
    logic            neg_s;

    alu_op_decode #(
        .WORD (WORD)
    ) u_decode (
        .opcode      (req_opcode),
        .b           (req_b),
        .mul_lat     (4'(MUL_LAT)),
        .div_lat     (4'(DIV_LAT)),
        .latency     (lat_s),
        .is_div_zero (dz_s),
        .is_illegal  (ill_s)
    );

    // Value to capture: forced to zero when the ALU output is meaningless.
    always_comb begin
        if (dz_r || ill_r) begin
            cap_s = {CW{1'b0}};
        end else begin
            cap_s = alu_c;
        end
        zero_s = (cap_s == {CW{1'b0}});
        neg_s  = cap_s[WORD-1];
    end

    // Issue/capture state machine with all outputs held in registers.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 4'd0;
            req_ready_r  <= 1'b1;
            res_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            alu_a_r      <= {WORD{1'b0}};
            alu_b_r      <= {WORD{1'b0}};
            alu_opcode_r <= OP_NOP;
            res_hi_r     <= {WORD{1'b0}};
            res_lo_r     <= {WORD{1'b0}};
            res_zero_r   <= 1'b0;
            res_neg_r    <= 1'b0;
            dz_r         <= 1'b0;
            ill_r        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        alu_a_r      <= req_a;
                        alu_b_r      <= req_b;
                        alu_opcode_r <= ill_s ? OP_NOP : req_opcode;
                        cnt_r        <= lat_s;
                        dz_r         <= dz_s;
                        ill_r        <= ill_s;
                        res_zero_r   <= 1'b0;
                        res_neg_r    <= 1'b0;
                        req_ready_r  <= 1'b0;
                        busy_r       <= 1'b1;
                        state_r      <= ST_EXEC;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    // A zero count cannot be loaded, but still terminates safely.
                    if (cnt_r <= 4'd1) begin
                        cnt_r        <= 4'd0;
                        res_hi_r     <= cap_s[CW-1:WORD];
                        res_lo_r     <= cap_s[WORD-1:0];
                        res_zero_r   <= zero_s;
                        res_neg_r    <= neg_s;
                        alu_opcode_r <= OP_NOP;
                        res_valid_r  <= 1'b1;
                        state_r      <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        res_valid_r <= 1'b0;
                        req_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    cnt_r        <= 4'd0;
                    alu_opcode_r <= OP_NOP;
                    res_valid_r  <= 1'b0;
                    req_ready_r  <= 1'b1;
                    busy_r       <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready    = req_ready_r;
    assign res_valid    = res_valid_r;
    assign busy         = busy_r;
    assign alu_a        = alu_a_r;
    assign alu_b        = alu_b_r;
    assign alu_opcode   = alu_opcode_r;
    assign alu_inc_pc   = 1'b0;
    assign alu_conn_out = 1'b0;
    assign res_hi       = res_hi_r;
    assign res_lo       = res_lo_r;
    assign res_zero     = res_zero_r;
    assign res_neg      = res_neg_r;
    assign res_dz       = dz_r;
    assign res_illegal  = ill_r;

endmodule
